motor_speed_ctrl: RTL



---
 rtl/motor_speed_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/motor_speed_ctrl.sv
// Motor speed sequencer: synchronized operator switches, duty setpoint, soft-start/soft-stop ramp.
// Optional emergency stop with a latched fault is enabled with `define MOTOR_CTRL_ESTOP_EN.
module motor_speed_ctrl #(
    parameter int DUTY_W    = 8,
    parameter int DUTY_STEP = 16,
    parameter int DUTY_INIT = 32,
    parameter int RAMP_DIV  = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              swt_start_stop,
    input  logic              swt_increase,
    input  logic              swt_decrease,
`ifdef MOTOR_CTRL_ESTOP_EN
    input  logic              estop,
    output logic              fault,
`endif
    output logic [DUTY_W-1:0] duty_target,
    output logic [DUTY_W-1:0] duty_out,
    output logic              pwm_en,
    output logic              motor_running,
    output logic              ramping
);

    // state        | meaning
    // ST_STANDBY   | motor off, duty forced to 0, PWM disabled
    // ST_RAMP_UP   | soft start, duty stepping toward the setpoint
    // ST_RUN       | setpoint reached, duty tracks setpoint changes
    // ST_RAMP_DOWN | soft stop, duty stepping down to 0
    typedef enum logic [1:0] {
        ST_STANDBY   = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RUN       = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } state_t;

    localparam int                CNT_W  = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CNT_W-1:0]  C_TC   = CNT_W'(RAMP_DIV - 1);
    localparam logic [DUTY_W:0]   C_STEP = (DUTY_W + 1)'(DUTY_STEP);

    state_t             r_state;
    logic [DUTY_W-1:0]  r_duty_target;
    logic [DUTY_W-1:0]  r_duty_out;
    logic               r_pwm_en;
    logic               r_running;
    logic               r_ramping;
    logic [CNT_W-1:0]   r_tick_cnt;
    logic               r_ss_s1, r_ss_s2;
    logic               r_inc_s1, r_inc_s2, r_inc_s3;
    logic               r_dec_s1, r_dec_s2, r_dec_s3;

    logic               w_tick;
    logic               w_inc_rise;
    logic               w_dec_rise;
    logic               w_start_ok;
    logic [DUTY_W:0]    w_inc_sum;
    logic [DUTY_W:0]    w_dec_diff;
    logic [DUTY_W-1:0]  w_target_nxt;
    logic [DUTY_W-1:0]  w_duty_toward;
    logic [DUTY_W-1:0]  w_duty_nxt;
    state_t             w_state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {r_ss_s1, r_ss_s2}             <= '0;
            {r_inc_s1, r_inc_s2, r_inc_s3} <= '0;
            {r_dec_s1, r_dec_s2, r_dec_s3} <= '0;
        end else begin
            {r_ss_s2, r_ss_s1}             <= {r_ss_s1, swt_start_stop};
            {r_inc_s3, r_inc_s2, r_inc_s1} <= {r_inc_s2, r_inc_s1, swt_increase};
            {r_dec_s3, r_dec_s2, r_dec_s1} <= {r_dec_s2, r_dec_s1, swt_decrease};
        end
    end

    assign w_inc_rise = r_inc_s2 & ~r_inc_s3;
    assign w_dec_rise = r_dec_s2 & ~r_dec_s3;
    assign w_tick     = (r_tick_cnt == C_TC);

`ifdef MOTOR_CTRL_ESTOP_EN
    logic r_es_s1, r_es_s2, r_fault;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {r_es_s1, r_es_s2} <= '0;
            r_fault            <= 1'b0;
        end else begin
            {r_es_s2, r_es_s1} <= {r_es_s1, estop};
            if (r_es_s2)
                r_fault <= 1'b1;
            else if (!r_ss_s2)
                r_fault <= 1'b0;
        end
    end

    assign w_start_ok = r_ss_s2 & ~r_fault;
    assign fault      = r_fault;
`else
    assign w_start_ok = r_ss_s2;
`endif

    // One extra bit catches both saturation at full scale and underflow below 0.
    assign w_inc_sum  = {1'b0, r_duty_target} + C_STEP;
    assign w_dec_diff = {1'b0, r_duty_target} - C_STEP;

    always_comb begin
        w_target_nxt = r_duty_target;
        if (w_inc_rise && !r_dec_s2)
            w_target_nxt = w_inc_sum[DUTY_W] ? '1 : w_inc_sum[DUTY_W-1:0];
        else if (w_dec_rise && !r_inc_s2)
            w_target_nxt = w_dec_diff[DUTY_W] ? '0 : w_dec_diff[DUTY_W-1:0];
    end

    always_comb begin
        w_duty_toward = r_duty_out;
        if (r_duty_out < r_duty_target)
            w_duty_toward = r_duty_out + 1'b1;
        else if (r_duty_out > r_duty_target)
            w_duty_toward = r_duty_out - 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty_out;
        case (r_state)
            ST_STANDBY: begin
                w_duty_nxt = '0;
                if (w_start_ok)
                    w_state_nxt = ST_RAMP_UP;
            end
            ST_RAMP_UP: begin
                if (w_tick)
                    w_duty_nxt = w_duty_toward;
                if (!r_ss_s2)
                    w_state_nxt = ST_RAMP_DOWN;
                else if (r_duty_out == r_duty_target)
                    w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_tick)
                    w_duty_nxt = w_duty_toward;
                if (!r_ss_s2)
                    w_state_nxt = ST_RAMP_DOWN;
            end
            ST_RAMP_DOWN: begin
                if (w_tick && (r_duty_out != '0))
                    w_duty_nxt = r_duty_out - 1'b1;
                if (r_ss_s2)
                    w_state_nxt = ST_RAMP_UP;
                else if (r_duty_out == '0)
                    w_state_nxt = ST_STANDBY;
            end
        endcase
`ifdef MOTOR_CTRL_ESTOP_EN
        if (r_es_s2) begin
            w_state_nxt = ST_STANDBY;
            w_duty_nxt  = '0;
        end
`endif
    end

    // Status outputs are derived from next-state values so they line up with the registered duty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_STANDBY;
            r_duty_target <= DUTY_W'(DUTY_INIT);
            r_duty_out    <= '0;
            r_pwm_en      <= 1'b0;
            r_running     <= 1'b0;
            r_ramping     <= 1'b0;
            r_tick_cnt    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_duty_target <= w_target_nxt;
            r_duty_out    <= w_duty_nxt;
            r_pwm_en      <= (w_state_nxt != ST_STANDBY);
            r_running     <= (w_state_nxt != ST_STANDBY);
            r_ramping     <= ((w_state_nxt != ST_STANDBY) && (w_duty_nxt != w_target_nxt))
                             || (w_state_nxt == ST_RAMP_DOWN);
            if (r_state == ST_STANDBY || w_tick)
                r_tick_cnt <= '0;
            else
                r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    assign duty_target   = r_duty_target;
    assign duty_out      = r_duty_out;
    assign pwm_en        = r_pwm_en;
    assign motor_running = r_running;
    assign ramping       = r_ramping;

endmodule
